// File: rtl/flash_attn_pkg.sv
// Shared types and defaults for the flash-attention tile loader.
// Helper returns a counter width of at least one bit for any bound.
package flash_attn_pkg;

  typedef enum logic [1:0] {
    SEL_Q = 2'd0,
    SEL_K = 2'd1,
    SEL_V = 2'd2
  } sel_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_Q = 3'd1,
    ST_LOAD_K = 3'd2,
    ST_LOAD_V = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_HEAD_D = 16;

  function automatic int clog2_min1(input int bound);
    if (bound <= 2) begin
      return 1;
    end else begin
      return $clog2(bound);
    end
  endfunction

endpackage

// File: rtl/flash_attn_skid_fifo.sv
// Two-entry synchronous FIFO with registered head/valid/count outputs.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module flash_attn_skid_fifo
  import flash_attn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       cnt_r;
  logic             valid_r;

  logic [WIDTH-1:0] head_s;
  logic [WIDTH-1:0] tail_s;
  logic [1:0]       cnt_s;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign pop_ok_s  = pop && (cnt_r != 2'd0);
  assign push_ok_s = push && ((cnt_r != 2'd2) || pop_ok_s);

  // Next head/tail/count from the push/pop combination
  always_comb begin
    head_s = head_r;
    tail_s = tail_r;
    cnt_s  = cnt_r;
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        if (cnt_r == 2'd0) begin
          head_s = din;
        end else begin
          tail_s = din;
        end
        cnt_s = cnt_r + 2'd1;
      end
      2'b01: begin
        head_s = tail_r;
        cnt_s  = cnt_r - 2'd1;
      end
      2'b11: begin
        if (cnt_r == 2'd1) begin
          head_s = din;
        end else begin
          head_s = tail_r;
          tail_s = din;
        end
      end
      default: begin
        head_s = head_r;
      end
    endcase
  end

  // Storage and registered output flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {WIDTH{1'b0}};
      tail_r  <= {WIDTH{1'b0}};
      cnt_r   <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      head_r  <= head_s;
      tail_r  <= tail_s;
      cnt_r   <= cnt_s;
      valid_r <= (cnt_s != 2'd0);
    end
  end

  assign dout  = head_r;
  assign valid = valid_r;
  assign cnt   = cnt_r;

endmodule

// File: rtl/flash_attn_tile_loader.sv
// Walks Q/K/V rows of a shared BRAM in flash-attention tile order and streams
// them, tagged with tile/row sideband, through a credit-limited 2-entry FIFO.
module flash_attn_tile_loader
  import flash_attn_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  HEAD_D   = DEF_HEAD_D,
  parameter int  SEQ_LEN  = 64,
  parameter int  BR       = 16,
  parameter int  BC       = 16,
  localparam int TR       = SEQ_LEN / BR,
  localparam int TC       = SEQ_LEN / BC,
  localparam int ADDR_W   = $clog2(3 * SEQ_LEN),
  localparam int TI_W     = clog2_min1(TR),
  localparam int TJ_W     = clog2_min1(TC),
  localparam int ROW_W    = clog2_min1((BR > BC) ? BR : BC),
  localparam int ROW_BITS = HEAD_D * DATA_W
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  input  logic                I_START,
  output logic                O_BRAM_EN,
  output logic [ADDR_W-1:0]   O_BRAM_ADDR,
  input  logic [ROW_BITS-1:0] I_BRAM_DATA,
  output logic                O_VALID,
  input  logic                I_READY,
  output logic [ROW_BITS-1:0] O_DATA,
  output logic [1:0]          O_SEL,
  output logic [TI_W-1:0]     O_TILE_I,
  output logic [TJ_W-1:0]     O_TILE_J,
  output logic [ROW_W-1:0]    O_ROW,
  output logic                O_LAST,
  output logic                O_BUSY,
  output logic                O_DONE
);

  localparam int SIDE_W = 2 + TI_W + TJ_W + ROW_W + 1;
  localparam int FIFO_W = ROW_BITS + SIDE_W;

  state_t             state_r;
  state_t             state_s;
  logic [ROW_W-1:0]   row_r;
  logic [ROW_W-1:0]   row_s;
  logic [TI_W-1:0]    tile_i_r;
  logic [TI_W-1:0]    tile_i_s;
  logic [TJ_W-1:0]    tile_j_r;
  logic [TJ_W-1:0]    tile_j_s;

  logic               inflight_r;
  logic [SIDE_W-1:0]  side_r;
  logic [SIDE_W-1:0]  side_s;

  sel_t               sel_s;
  logic [ADDR_W-1:0]  addr_s;
  logic               issuing_s;
  logic               row_last_s;
  logic [TJ_W-1:0]    tile_j_tag_s;
  logic [2:0]         occ_s;
  logic               en_s;
  logic               pop_s;
  logic               done_s;

  logic [FIFO_W-1:0]  fifo_dout;
  logic               fifo_valid;
  logic [1:0]         fifo_cnt;

  // Matrix select and BRAM address decoded from the walk counters
  always_comb begin
    sel_s     = SEL_Q;
    addr_s    = {ADDR_W{1'b0}};
    issuing_s = 1'b0;
    case (state_r)
      ST_LOAD_Q: begin
        sel_s     = SEL_Q;
        issuing_s = 1'b1;
        addr_s    = ADDR_W'(tile_i_r) * ADDR_W'(BR) + ADDR_W'(row_r);
      end
      ST_LOAD_K: begin
        sel_s     = SEL_K;
        issuing_s = 1'b1;
        addr_s    = ADDR_W'(SEQ_LEN) + ADDR_W'(tile_j_r) * ADDR_W'(BC) + ADDR_W'(row_r);
      end
      ST_LOAD_V: begin
        sel_s     = SEL_V;
        issuing_s = 1'b1;
        addr_s    = ADDR_W'(2 * SEQ_LEN) + ADDR_W'(tile_j_r) * ADDR_W'(BC) + ADDR_W'(row_r);
      end
      default: begin
        issuing_s = 1'b0;
      end
    endcase
  end

  assign row_last_s   = (state_r == ST_LOAD_Q) ? (row_r == ROW_W'(BR - 1))
                                               : (row_r == ROW_W'(BC - 1));
  assign tile_j_tag_s = (state_r == ST_LOAD_Q) ? {TJ_W{1'b0}} : tile_j_r;
  assign side_s       = {sel_s, tile_i_r, tile_j_tag_s, row_r, row_last_s};

  // Credits: buffered rows plus the read in flight, less the row leaving now.
  // This deliberately makes I_READY reach O_BRAM_EN combinationally.
  assign pop_s  = fifo_valid & I_READY;
  assign occ_s  = {1'b0, fifo_cnt} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign en_s   = issuing_s && (occ_s < 3'd2);
  assign done_s = (state_r == ST_DRAIN) && !inflight_r && (fifo_cnt == 2'd1) && pop_s;

  // Next-state and walk-counter advance, one row per issued read
  always_comb begin
    state_s  = state_r;
    row_s    = row_r;
    tile_i_s = tile_i_r;
    tile_j_s = tile_j_r;
    case (state_r)
      ST_IDLE: begin
        if (I_START) begin
          state_s = ST_LOAD_Q;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_Q: begin
        if (en_s && row_last_s) begin
          row_s   = {ROW_W{1'b0}};
          state_s = ST_LOAD_K;
        end else if (en_s) begin
          row_s = row_r + ROW_W'(1'b1);
        end else begin
          row_s = row_r;
        end
      end
      ST_LOAD_K: begin
        if (en_s && row_last_s) begin
          row_s   = {ROW_W{1'b0}};
          state_s = ST_LOAD_V;
        end else if (en_s) begin
          row_s = row_r + ROW_W'(1'b1);
        end else begin
          row_s = row_r;
        end
      end
      ST_LOAD_V: begin
        if (en_s && row_last_s) begin
          row_s = {ROW_W{1'b0}};
          if (tile_j_r == TJ_W'(TC - 1)) begin
            tile_j_s = {TJ_W{1'b0}};
            if (tile_i_r == TI_W'(TR - 1)) begin
              tile_i_s = {TI_W{1'b0}};
              state_s  = ST_DRAIN;
            end else begin
              tile_i_s = tile_i_r + TI_W'(1'b1);
              state_s  = ST_LOAD_Q;
            end
          end else begin
            tile_j_s = tile_j_r + TJ_W'(1'b1);
            state_s  = ST_LOAD_K;
          end
        end else if (en_s) begin
          row_s = row_r + ROW_W'(1'b1);
        end else begin
          row_s = row_r;
        end
      end
      ST_DRAIN: begin
        if (done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and walk counters
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_r  <= ST_IDLE;
      row_r    <= {ROW_W{1'b0}};
      tile_i_r <= {TI_W{1'b0}};
      tile_j_r <= {TJ_W{1'b0}};
    end else begin
      state_r  <= state_s;
      row_r    <= row_s;
      tile_i_r <= tile_i_s;
      tile_j_r <= tile_j_s;
    end
  end

  // Sideband delayed to line up with the one-cycle BRAM read data
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      inflight_r <= 1'b0;
      side_r     <= {SIDE_W{1'b0}};
    end else begin
      inflight_r <= en_s;
      if (en_s) begin
        side_r <= side_s;
      end else begin
        side_r <= side_r;
      end
    end
  end

  flash_attn_skid_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (I_CLK),
    .rst   (I_RST),
    .push  (inflight_r),
    .pop   (pop_s),
    .din   ({I_BRAM_DATA, side_r}),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .cnt   (fifo_cnt)
  );

  assign {O_DATA, O_SEL, O_TILE_I, O_TILE_J, O_ROW, O_LAST} = fifo_dout;

  assign O_VALID     = fifo_valid;
  assign O_BRAM_EN   = en_s;
  assign O_BRAM_ADDR = addr_s;
  assign O_BUSY      = (state_r != ST_IDLE);
  assign O_DONE      = done_s;

endmodule

// File: tb/tb_flash_attn_tile_loader.sv
// Scoreboard bench: directed runs push the ideal row order, a negedge monitor
// pops and compares every accepted row, plus timing/credit/reset checks.
module tb_flash_attn_tile_loader;

  localparam int DATA_W  = 16;
  localparam int HEAD_D  = 4;
  localparam int SEQ_LEN = 32;
  localparam int BR      = 8;
  localparam int BC      = 8;
  localparam int NROWS   = 288;

  typedef struct packed {
    logic [6:0] addr;
    logic [1:0] sel;
    logic [1:0] ti;
    logic [1:0] tj;
    logic [2:0] row;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        bram_en;
  logic [6:0]  bram_addr;
  logic [63:0] bram_data;
  logic        valid;
  logic        ready;
  logic [63:0] data;
  logic [1:0]  sel;
  logic [1:0]  ti;
  logic [1:0]  tj;
  logic [2:0]  row;
  logic        last;
  logic        busy;
  logic        done;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          run_pops = 0;
  int          outstanding = 0;

  logic        prev_valid;
  logic        prev_ready;
  logic [73:0] prev_bundle;
  logic [73:0] cur;
  logic [73:0] expb;
  exp_t        e;

  flash_attn_tile_loader #(
    .DATA_W  (DATA_W),
    .HEAD_D  (HEAD_D),
    .SEQ_LEN (SEQ_LEN),
    .BR      (BR),
    .BC      (BC)
  ) dut (
    .I_CLK       (clk),
    .I_RST       (rst),
    .I_START     (start),
    .O_BRAM_EN   (bram_en),
    .O_BRAM_ADDR (bram_addr),
    .I_BRAM_DATA (bram_data),
    .O_VALID     (valid),
    .I_READY     (ready),
    .O_DATA      (data),
    .O_SEL       (sel),
    .O_TILE_I    (ti),
    .O_TILE_J    (tj),
    .O_ROW       (row),
    .O_LAST      (last),
    .O_BUSY      (busy),
    .O_DONE      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] row_data(input logic [6:0] a);
    return {4{{9'd0, a}}};
  endfunction

  // BRAM model: each element holds its own row address
  always @(posedge clk) begin
    if (bram_en) bram_data <= row_data(bram_addr);
  end

  task automatic check(input bit ok, input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_row(input int a, input int s, input int i, input int j, input int r);
    exp_t x;
    x.addr = 7'(a);
    x.sel  = 2'(s);
    x.ti   = 2'(i);
    x.tj   = 2'(j);
    x.row  = 3'(r);
    x.last = (r == 7);
    exp_q.push_back(x);
  endtask

  task automatic build_expected();
    exp_q.delete();
    run_pops = 0;
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 8; r++) push_row(i * 8 + r, 0, i, 0, r);
      for (int j = 0; j < 4; j++) begin
        for (int r = 0; r < 8; r++) push_row(32 + j * 8 + r, 1, i, j, r);
        for (int r = 0; r < 8; r++) push_row(64 + j * 8 + r, 2, i, j, r);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [84:0] all_outs();
    return {bram_en, bram_addr, valid, data, sel, ti, tj, row, last, busy, done};
  endfunction

  task automatic run_until_done(input int first_c, input int limit, input bit rand_ready,
                                input int pulse_a, input int pulse_b, output int cyc);
    cyc = 0;
    for (int c = first_c; c <= limit; c++) begin
      tick();
      start = (c == pulse_a) || (c == pulse_b);
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
    end
    check(cyc != 0, "done_seen", cyc, limit);
    if (cyc != 0) check(busy == 1'b1, "busy_at_done", busy, 1);
  endtask

  // Monitor: scoreboard pop, handshake stability, done and credit bound
  initial begin
    prev_valid  = 1'b0;
    prev_ready  = 1'b0;
    prev_bundle = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid  = 1'b0;
        outstanding = 0;
      end else begin
        cur = {data, sel, ti, tj, row, last};
        if (prev_valid && !prev_ready)
          check(valid && (cur == prev_bundle), "hold_stable", {valid, cur}, {1'b1, prev_bundle});
        if (valid && ready) begin
          check(exp_q.size() != 0, "extra_row", cur, 0);
          if (exp_q.size() != 0) begin
            e    = exp_q.pop_front();
            expb = {row_data(e.addr), e.sel, e.ti, e.tj, e.row, e.last};
            check(cur == expb, "row", cur, expb);
          end
          run_pops++;
        end
        if (done)
          check(valid && ready && (exp_q.size() == 0) && (run_pops == NROWS), "done_pulse", run_pops, NROWS);
        outstanding = outstanding + int'(bram_en) - int'(valid && ready);
        check((outstanding >= 0) && (outstanding <= 2), "credit_bound", outstanding, 2);
        prev_valid  = valid;
        prev_ready  = ready;
        prev_bundle = cur;
      end
    end
  end

  initial begin
    int cyc;
    int issued;
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check(all_outs() == 85'd0, "reset_outputs", all_outs(), 0);
    tick();
    rst = 1'b0;
    tick();

    // Full-rate run with starts while busy and on the done cycle
    build_expected();
    pulse_start();
    @(negedge clk);
    check(busy && bram_en && (bram_addr == 7'd0) && !valid, "cycle1", {busy, bram_en, bram_addr, valid}, 10'h300);
    tick();
    @(negedge clk);
    check(!valid, "cycle2_no_valid", valid, 0);
    tick();
    @(negedge clk);
    check(valid && (data == 64'd0) && (sel == 2'd0), "cycle3_first_row", {valid, data}, {1'b1, 64'd0});
    run_until_done(4, 400, 1'b0, 50, 290, cyc);
    check(cyc == 290, "full_rate_done_cycle", cyc, 290);
    tick();
    start = 1'b0;
    @(negedge clk);
    check(!busy, "busy_falls", busy, 0);
    issued = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      issued += int'(busy) + int'(bram_en) + int'(valid);
    end
    check(issued == 0, "no_second_run", issued, 0);
    check(run_pops == NROWS, "run_a_rows", run_pops, NROWS);

    // Random backpressure
    build_expected();
    ready = 1'($urandom_range(0, 1));
    pulse_start();
    run_until_done(1, 4000, 1'b1, -1, -1, cyc);
    check(exp_q.size() == 0, "random_all_rows", exp_q.size(), 0);
    ready = 1'b1;
    repeat (3) tick();

    // Stall right after start: only two reads may be issued
    build_expected();
    ready = 1'b0;
    pulse_start();
    issued = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      issued += int'(bram_en);
      if (c < 20) tick();
    end
    check(issued == 2, "stall_reads", issued, 2);
    check(!bram_en && valid, "stall_state", {bram_en, valid}, 2'b01);
    tick();
    ready = 1'b1;
    @(negedge clk);
    check(bram_en == 1'b1, "credit_on_pop", bram_en, 1);
    run_until_done(22, 1000, 1'b0, -1, -1, cyc);
    check(cyc == 308, "stall_done_cycle", cyc, 308);
    repeat (3) tick();

    // Reset in the middle of the first V tile, then restart
    build_expected();
    pulse_start();
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    @(negedge clk);
    check(all_outs() == 85'd0, "midrun_reset", all_outs(), 0);
    exp_q.delete();
    tick();
    @(negedge clk);
    check(all_outs() == 85'd0, "reset_next_cycle", all_outs(), 0);
    tick();
    rst = 1'b0;
    tick();
    build_expected();
    pulse_start();
    @(negedge clk);
    check(busy && bram_en && (bram_addr == 7'd0), "restart_addr0", {busy, bram_en, bram_addr}, 9'h180);
    tick();
    tick();
    @(negedge clk);
    check(valid && (ti == 2'd0) && (data == 64'd0), "restart_first_row", {valid, ti, data}, {1'b1, 2'd0, 64'd0});
    run_until_done(4, 400, 1'b0, -1, -1, cyc);
    check(cyc == 290, "restart_done_cycle", cyc, 290);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
